// File: rtl/dds_reg_readback.sv
// rtl/dds_reg_readback.sv - snapshot 16 4-bit DDS config registers and stream them as a framed byte sequence (optional checksum: DDS_READBACK_CHECKSUM_EN)
module dds_reg_readback #(
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         GAP_CYCLES  = 0,
    parameter int         GAP_W       = 16
) (
    input  logic        clk_in,
    input  logic        rstn_in,
    input  logic        req_in,
    input  logic [63:0] regs_in,
    input  logic        tx_ready_in,
    output logic [7:0]  tx_data_out,
    output logic        tx_valid_out,
    output logic        busy_out,
    output logic        done_out
);

`ifdef DDS_READBACK_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CHK, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_GAP} state_t;
`endif

    localparam bit              GAP_EN   = (GAP_CYCLES > 0);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state;
    state_t             resume;
    logic [63:0]        snap;
    logic [3:0]         idx;
    logic [GAP_W-1:0]   gap_cnt;
`ifdef DDS_READBACK_CHECKSUM_EN
    logic [7:0]         chk;
`endif

    logic       xfer;
    logic [3:0] next_idx;
    logic [3:0] cur_nib;
    logic [3:0] next_nib;

    assign xfer     = tx_valid_out & tx_ready_in;
    assign next_idx = idx + 4'd1;
    assign cur_nib  = snap[{idx, 2'b00} +: 4];
    assign next_nib = snap[{next_idx, 2'b00} +: 4];

    // Frame sequencer: all outputs registered; the next byte is loaded on the transfer edge
    // (or at the end of the gap) so tx_data_out only changes after an accepted byte.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state        <= S_IDLE;
            resume       <= S_IDLE;
            snap         <= '0;
            idx          <= '0;
            gap_cnt      <= '0;
`ifdef DDS_READBACK_CHECKSUM_EN
            chk          <= '0;
`endif
            tx_data_out  <= 8'h00;
            tx_valid_out <= 1'b0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_in) begin
                        snap         <= regs_in;
                        idx          <= '0;
                        gap_cnt      <= '0;
`ifdef DDS_READBACK_CHECKSUM_EN
                        chk          <= '0;
`endif
                        busy_out     <= 1'b1;
                        tx_valid_out <= 1'b1;
                        tx_data_out  <= HEADER_BYTE;
                        state        <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (xfer) begin
`ifdef DDS_READBACK_CHECKSUM_EN
                        chk <= chk ^ tx_data_out;
`endif
                        if (GAP_EN) begin
                            tx_valid_out <= 1'b0;
                            gap_cnt      <= GAP_LOAD;
                            resume       <= S_DATA;
                            state        <= S_GAP;
                        end else begin
                            tx_data_out <= {4'h0, snap[3:0]};
                            state       <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
`ifdef DDS_READBACK_CHECKSUM_EN
                        chk <= chk ^ tx_data_out;
`endif
                        if (idx == 4'd15) begin
`ifdef DDS_READBACK_CHECKSUM_EN
                            if (GAP_EN) begin
                                tx_valid_out <= 1'b0;
                                gap_cnt      <= GAP_LOAD;
                                resume       <= S_CHK;
                                state        <= S_GAP;
                            end else begin
                                tx_data_out <= chk ^ tx_data_out;
                                state       <= S_CHK;
                            end
`else
                            tx_valid_out <= 1'b0;
                            busy_out     <= 1'b0;
                            done_out     <= 1'b1;
                            state        <= S_IDLE;
`endif
                        end else begin
                            idx <= next_idx;
                            if (GAP_EN) begin
                                tx_valid_out <= 1'b0;
                                gap_cnt      <= GAP_LOAD;
                                resume       <= S_DATA;
                                state        <= S_GAP;
                            end else begin
                                tx_data_out <= {next_idx, next_nib};
                            end
                        end
                    end
                end
`ifdef DDS_READBACK_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        tx_valid_out <= 1'b0;
                        busy_out     <= 1'b0;
                        done_out     <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
`endif
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        tx_valid_out <= 1'b1;
                        state        <= resume;
`ifdef DDS_READBACK_CHECKSUM_EN
                        tx_data_out  <= (resume == S_CHK) ? chk : {idx, cur_nib};
`else
                        tx_data_out  <= {idx, cur_nib};
`endif
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
